// File: rtl/acc_alu_seq_if.sv
// rtl/acc_alu_seq_if.sv - bus/control handshake between the control unit and the accumulator ALU
interface acc_alu_seq_if #(
  parameter int W = 8
);
  logic [W-1:0] BusOut;
  logic         Wen;
  logic         INC;
  logic         CLR;
  logic         start;
  logic [2:0]   alu_op;
  logic [W-1:0] dout;
  logic         busy;
  logic         done;
  logic         Cf;
  logic         Zf;
  logic         Nf;

  modport master (
    output BusOut, Wen, INC, CLR, start, alu_op,
    input  dout, busy, done, Cf, Zf, Nf
  );

  modport slave (
    input  BusOut, Wen, INC, CLR, start, alu_op,
    output dout, busy, done, Cf, Zf, Nf
  );
endinterface

// File: rtl/acc_alu_seq.sv
// rtl/acc_alu_seq.sv - W-bit accumulator ALU with single-cycle ops and shift-add multiply
module acc_alu_seq #(
  parameter int W      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic          Clk,
  input  logic          RSTn,
  acc_alu_seq_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ac_q, ac_d;
  logic           cf_q, cf_d;
  logic           done_q, done_d;
  logic           mul_start;
  logic [2*W-1:0] mcand_q, prod_q, prod_step;
  logic [W-1:0]   mplr_q;
  logic [CW-1:0]  cnt_q;
  logic           last_step;
  logic [W:0]     ext;

  // Final step folds into the write-back edge so busy lasts exactly W cycles.
  assign prod_step = prod_q + (mplr_q[0] ? mcand_q : '0);
  assign last_step = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    cf_d      = cf_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    ext       = '0;
    if (bus.CLR) begin
      ac_d    = '0;
      cf_d    = 1'b0;
      state_d = S_IDLE;
    end else if (state_q == S_MUL) begin
      if (last_step) begin
        ac_d    = prod_step[W-1:0];
        cf_d    = |prod_step[2*W-1:W];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end else if (bus.Wen) begin
      ac_d = bus.BusOut;
      cf_d = 1'b0;
    end else if (bus.INC) begin
      ext  = {1'b0, ac_q} + (W+1)'(1);
      ac_d = ext[W-1:0];
      cf_d = ext[W];
    end else if (bus.start) begin
      done_d = 1'b1;
      case (bus.alu_op)
        3'b001: begin
          ext  = {1'b0, ac_q} + {1'b0, bus.BusOut};
          ac_d = ext[W-1:0];
          cf_d = ext[W];
        end
        3'b010: begin
          ext  = {1'b0, ac_q} - {1'b0, bus.BusOut};
          ac_d = ext[W-1:0];
          cf_d = ext[W];
        end
        3'b011: begin ac_d = ac_q & bus.BusOut; cf_d = 1'b0; end
        3'b100: begin ac_d = ac_q | bus.BusOut; cf_d = 1'b0; end
        3'b101: begin ac_d = ac_q ^ bus.BusOut; cf_d = 1'b0; end
        3'b110: begin
          if (MUL_EN) begin
            mul_start = 1'b1;
            done_d    = 1'b0;
            state_d   = S_MUL;
          end
        end
        3'b111: begin ac_d = {1'b0, ac_q[W-1:1]}; cf_d = ac_q[0]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      ac_q    <= '0;
      cf_q    <= 1'b0;
      done_q  <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      cf_q    <= cf_d;
      done_q  <= done_d;
      if (mul_start) begin
        mcand_q <= {{W{1'b0}}, ac_q};
        mplr_q  <= bus.BusOut;
        prod_q  <= '0;
        cnt_q   <= '0;
      end else if (state_q == S_MUL && !bus.CLR) begin
        prod_q  <= prod_step;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.dout = ac_q;
  assign bus.busy = (state_q == S_MUL);
  assign bus.done = done_q;
  assign bus.Cf   = cf_q;
  assign bus.Zf   = (ac_q == '0);
  assign bus.Nf   = ac_q[W-1];
endmodule

// File: tb/tb_acc_alu_seq.sv
// tb/tb_acc_alu_seq.sv - self-checking bench for acc_alu_seq (W=8 with MUL, W=16 without MUL)
module tb_acc_alu_seq;
  logic Clk = 1'b0;
  logic RSTn = 1'b0;
  always #5 Clk = ~Clk;

  acc_alu_seq_if #(.W(8))  bus8 ();
  acc_alu_seq_if #(.W(16)) bus16 ();

  acc_alu_seq #(.W(8), .MUL_EN(1'b1)) u_dut8 (.Clk(Clk), .RSTn(RSTn), .bus(bus8));
  acc_alu_seq #(.W(16), .MUL_EN(1'b0)) u_dut16 (.Clk(Clk), .RSTn(RSTn), .bus(bus16));

  typedef struct {
    logic [15:0] dout;
    logic        cf;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic       wen, inc, clr, start;
    logic [2:0] op;
    logic [7:0] bus;
    logic [7:0] dout;
    logic       cf, done;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  int checks = 0;
  int failures = 0;

  longint m_ac[2], m_mc[2], m_mp[2];
  int     m_cnt[2];
  bit     m_cf[2], m_done[2];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ac[i] = 0; m_mc[i] = 0; m_mp[i] = 0; m_cnt[i] = 0; m_cf[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step(input int id, input int w, input bit mul_en,
                            input logic wen, inc, clr, start, input logic [2:0] op,
                            input logic [15:0] b);
    longint mask, ac, bb, r;
    mask = (longint'(1) << w) - 1;
    ac = m_ac[id];
    bb = longint'(b) & mask;
    m_done[id] = 0;
    if (clr) begin
      ac = 0; m_cf[id] = 0; m_cnt[id] = 0;
    end else if (m_cnt[id] > 0) begin
      m_cnt[id]--;
      if (m_cnt[id] == 0) begin
        r = m_mc[id] * m_mp[id];
        ac = r & mask; m_cf[id] = ((r >> w) != 0); m_done[id] = 1;
      end
    end else if (wen) begin
      ac = bb; m_cf[id] = 0;
    end else if (inc) begin
      r = ac + 1; m_cf[id] = (r > mask); ac = r & mask;
    end else if (start) begin
      m_done[id] = 1;
      case (op)
        3'd1: begin r = ac + bb; m_cf[id] = ((r >> w) != 0); ac = r & mask; end
        3'd2: begin m_cf[id] = (ac < bb); ac = (ac - bb) & mask; end
        3'd3: begin ac = ac & bb; m_cf[id] = 0; end
        3'd4: begin ac = ac | bb; m_cf[id] = 0; end
        3'd5: begin ac = ac ^ bb; m_cf[id] = 0; end
        3'd6: if (mul_en) begin m_mc[id] = ac; m_mp[id] = bb; m_cnt[id] = w; m_done[id] = 0; end
        3'd7: begin m_cf[id] = ac[0]; ac = ac >> 1; end
        default: ;
      endcase
    end
    m_ac[id] = ac;
  endtask

  task automatic tick(input string tag, input logic wen, inc, clr, start, input logic [2:0] op,
                      input logic [7:0] b8, input logic [15:0] b16, input bit use_tbl, input exp_t te);
    exp_t e;
    @(negedge Clk);
    bus8.Wen = wen;  bus8.INC = inc;  bus8.CLR = clr;  bus8.start = start;  bus8.alu_op = op;  bus8.BusOut = b8;
    bus16.Wen = wen; bus16.INC = inc; bus16.CLR = clr; bus16.start = start; bus16.alu_op = op; bus16.BusOut = b16;
    model_step(0, 8, 1'b1, wen, inc, clr, start, op, {8'h00, b8});
    model_step(1, 16, 1'b0, wen, inc, clr, start, op, b16);
    e.dout = 16'(m_ac[0]); e.cf = m_cf[0]; e.busy = (m_cnt[0] > 0); e.done = m_done[0];
    q8.push_back(use_tbl ? te : e);
    e.dout = 16'(m_ac[1]); e.cf = m_cf[1]; e.busy = (m_cnt[1] > 0); e.done = m_done[1];
    q16.push_back(e);
    @(posedge Clk);
    #1;
    e = q8.pop_front();
    chk({tag, ".dout8"}, 16'(bus8.dout), e.dout);
    chk({tag, ".cf8"},   16'(bus8.Cf),   16'(e.cf));
    chk({tag, ".busy8"}, 16'(bus8.busy), 16'(e.busy));
    chk({tag, ".done8"}, 16'(bus8.done), 16'(e.done));
    chk({tag, ".zf8"},   16'(bus8.Zf),   16'(e.dout[7:0] == 8'h00));
    chk({tag, ".nf8"},   16'(bus8.Nf),   16'(e.dout[7]));
    e = q16.pop_front();
    chk({tag, ".dout16"}, bus16.dout,     e.dout);
    chk({tag, ".cf16"},   16'(bus16.Cf),  16'(e.cf));
    chk({tag, ".busy16"}, 16'(bus16.busy), 16'(e.busy));
    chk({tag, ".done16"}, 16'(bus16.done), 16'(e.done));
    chk({tag, ".zf16"},   16'(bus16.Zf),  16'(e.dout == 16'h0000));
    chk({tag, ".nf16"},   16'(bus16.Nf),  16'(e.dout[15]));
  endtask

  task automatic idle(input string tag);
    exp_t z;
    z = '{default: '0};
    tick(tag, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 16'h0000, 1'b0, z);
  endtask

  task automatic op8(input string tag, input logic wen, inc, clr, start,
                     input logic [2:0] op, input logic [7:0] b);
    exp_t z;
    z = '{default: '0};
    tick(tag, wen, inc, clr, start, op, b, {8'h00, b}, 1'b0, z);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".dout8"}, 16'(bus8.dout), 16'h0);
    chk({tag, ".cf8"},   16'(bus8.Cf),   16'h0);
    chk({tag, ".busy8"}, 16'(bus8.busy), 16'h0);
    chk({tag, ".done8"}, 16'(bus8.done), 16'h0);
    chk({tag, ".zf8"},   16'(bus8.Zf),   16'h1);
    chk({tag, ".nf8"},   16'(bus8.Nf),   16'h0);
    chk({tag, ".dout16"}, bus16.dout,    16'h0);
    chk({tag, ".zf16"},  16'(bus16.Zf),  16'h1);
  endtask

  function automatic vec_t mk(input logic wen, inc, clr, start, input logic [2:0] op,
                              input logic [7:0] b, input logic [7:0] d, input logic cf, done);
    vec_t v;
    v.wen = wen; v.inc = inc; v.clr = clr; v.start = start; v.op = op;
    v.bus = b; v.dout = d; v.cf = cf; v.done = done;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    exp_t te;
    int nb, nd;
    logic [15:0] d_at_done, cf_at_done;

    bus8.Wen = 0;  bus8.INC = 0;  bus8.CLR = 0;  bus8.start = 0;  bus8.alu_op = 0;  bus8.BusOut = 0;
    bus16.Wen = 0; bus16.INC = 0; bus16.CLR = 0; bus16.start = 0; bus16.alu_op = 0; bus16.BusOut = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    RSTn = 1'b1;

    //        wen inc clr st op    bus    dout   cf done
    tbl.push_back(mk(1, 0, 0, 0, 3'd0, 8'd35,  8'd35,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3'd0, 8'd0,   8'd36,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3'd0, 8'd0,   8'd37,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'd0, 8'd255, 8'd255, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3'd0, 8'd0,   8'd0,   1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'd0, 8'd100, 8'd100, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'd1, 8'd200, 8'd44,  1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 8'd0,   8'd44,  1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'd0, 8'd5,   8'd5,   0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'd2, 8'd6,   8'd255, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 8'd0,   8'd255, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'd3, 8'h0F,  8'h0F,  0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 3'd4, 8'h30,  8'h3F,  0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 3'd5, 8'hFF,  8'hC0,  0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 3'd7, 8'h00,  8'h60,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'd0, 8'd3,   8'd3,   0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'd7, 8'h00,  8'd1,   1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 3'd0, 8'h55,  8'd1,   1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'd0, 8'hAA,  8'hAA,  0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3'd0, 8'h00,  8'h00,  0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'd1, 8'd7,   8'd7,   0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3'd1, 8'd5,   8'd8,   0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd0, 8'd9,   8'd0,   0, 0));
    foreach (tbl[i]) begin
      te.dout = {8'h00, tbl[i].dout}; te.cf = tbl[i].cf; te.busy = 1'b0; te.done = tbl[i].done;
      tick($sformatf("vec%0d", i), tbl[i].wen, tbl[i].inc, tbl[i].clr, tbl[i].start, tbl[i].op,
           tbl[i].bus, {8'h00, tbl[i].bus}, 1'b1, te);
    end

    // 12 * 13: busy for exactly W cycles, loads/incs during busy are dropped
    op8("mul.load", 1, 0, 0, 0, 3'd0, 8'd12);
    op8("mul.start", 0, 0, 0, 1, 3'd6, 8'd13);
    nb = bus8.busy ? 1 : 0;
    nd = 0; d_at_done = '0; cf_at_done = '0;
    for (int i = 0; i < 10; i++) begin
      op8($sformatf("mul.c%0d", i), (i == 2), (i == 4), 0, 0, 3'd0, 8'd99);
      if (bus8.busy) nb++;
      if (bus8.done) begin nd++; d_at_done = 16'(bus8.dout); cf_at_done = 16'(bus8.Cf); end
    end
    chk("mul.busy_cycles", 16'(nb), 16'd8);
    chk("mul.done_pulses", 16'(nd), 16'd1);
    chk("mul.result", d_at_done, 16'd156);
    chk("mul.cf", cf_at_done, 16'd0);

    // 20 * 20 overflow; start on the write-back edge ignored, next edge accepted
    op8("b2b.load", 1, 0, 0, 0, 3'd0, 8'd20);
    op8("b2b.start", 0, 0, 0, 1, 3'd6, 8'd20);
    for (int i = 0; i < 7; i++) idle($sformatf("b2b.w%0d", i));
    op8("b2b.wb", 0, 0, 0, 1, 3'd1, 8'd1);
    chk("b2b.result", 16'(bus8.dout), 16'd144);
    chk("b2b.cf", 16'(bus8.Cf), 16'd1);
    chk("b2b.done", 16'(bus8.done), 16'd1);
    op8("b2b.next", 0, 0, 0, 1, 3'd1, 8'd1);
    chk("b2b.accepted", 16'(bus8.dout), 16'd145);
    chk("b2b.accepted_done", 16'(bus8.done), 16'd1);

    // CLR in the 4th busy cycle aborts with no done
    op8("abort.load", 1, 0, 0, 0, 3'd0, 8'd12);
    op8("abort.start", 0, 0, 0, 1, 3'd6, 8'd13);
    for (int i = 0; i < 3; i++) idle($sformatf("abort.w%0d", i));
    op8("abort.clr", 0, 0, 1, 0, 3'd0, 8'd0);
    chk("abort.dout", 16'(bus8.dout), 16'd0);
    chk("abort.busy", 16'(bus8.busy), 16'd0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      idle($sformatf("abort.i%0d", i));
      if (bus8.done) nd++;
    end
    chk("abort.no_done", 16'(nd), 16'd0);

    // asynchronous reset in the middle of a multiply
    op8("areset.load", 1, 0, 0, 0, 3'd0, 8'd200);
    op8("areset.start", 0, 0, 0, 1, 3'd6, 8'd3);
    idle("areset.w0");
    #2 RSTn = 1'b0;
    #1 check_reset_outputs("areset");
    model_reset();
    @(negedge Clk);
    RSTn = 1'b1;
    idle("areset.after");

    for (int i = 0; i < 200; i++) begin
      logic [15:0] r16;
      logic [7:0]  r8;
      exp_t z;
      z = '{default: '0};
      r16 = 16'($urandom);
      r8  = 8'($urandom);
      tick($sformatf("rnd%0d", i), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
           r8, r16, 1'b0, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
